// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: icode values, absent-register code, fetch FSM states, length helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [2:0] {
        FETCH0   = 3'd0,
        FETCHREG = 3'd1,
        FETCHC   = 3'd2,
        PRESENT  = 3'd3,
        WAITPC   = 3'd4,
        HALT     = 3'd5
    } fetch_state_e;

    // Encoded length in bytes; codes outside the ISA fall back to a single byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
            I_JXX, I_CALL:                    instr_len = 4'd9;
            default:                          instr_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_len_decode_64.sv
// Classifies an icode into its byte layout: register-id byte, 8-byte constant, or illegal.
// Latency: combinational.
// Backpressure: none; pure function of the icode.
module fetch_len_decode_64
    import y86_pkg::*;
#(
    parameter logic [3:0] MAX_ICODE = 4'hB
) (
    input  logic [3:0] icode_i,
    output logic       needs_regids_o,
    output logic       needs_valc_o,
    output logic       illegal_o
);

    // Illegal codes carry no extra bytes so the fetcher presents them after byte 0.
    always_comb begin
        needs_regids_o = 1'b0;
        needs_valc_o   = 1'b0;
        illegal_o      = (icode_i > MAX_ICODE);
        if (!illegal_o) begin
            case (icode_i)
                I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: needs_regids_o = 1'b1;
                I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                    needs_regids_o = 1'b1;
                    needs_valc_o   = 1'b1;
                end
                I_JXX, I_CALL: needs_valc_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_seq_64.sv
// Y86-64 SEQ fetch: reads an instruction byte-serially from imem, decodes fields, presents them.
// Latency: one imem handshake per instruction byte, then held in PRESENT until accepted.
// Backpressure: out_valid holds all fields stable until out_ready; imem_req held until imem_ack.
module fetch_seq_64
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [3:0]  MAX_ICODE = 4'hB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc,
    output logic        instr_err,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  valc_q, valc_d;
    logic [63:0]  valp_q, valp_d;
    logic [3:0]   icode_q, icode_d;
    logic [3:0]   ifun_q, ifun_d;
    logic [3:0]   ra_q, ra_d;
    logic [3:0]   rb_q, rb_d;
    logic [3:0]   idx_q, idx_d;
    logic [2:0]   kidx_q, kidx_d;
    logic         req_q, req_d;
    logic         err_q, err_d;
    logic         halted_q, halted_d;

    logic         byte_vld;
    logic [3:0]   dec_icode;
    logic         dec_regids;
    logic         dec_valc;
    logic         dec_illegal;
    logic [3:0]   len0;

    // An ack only counts while our own request is up.
    assign byte_vld  = req_q & imem_ack;
    // Byte 0 is classified straight off the bus; later bytes use the captured icode.
    assign dec_icode = (state_q == FETCH0) ? imem_rdata[7:4] : icode_q;
    assign len0      = dec_illegal ? 4'd1 : instr_len(dec_icode);

    fetch_len_decode_64 #(
        .MAX_ICODE(MAX_ICODE)
    ) u_len_dec (
        .icode_i        (dec_icode),
        .needs_regids_o (dec_regids),
        .needs_valc_o   (dec_valc),
        .illegal_o      (dec_illegal)
    );

    // Next-state: byte sequencing, field capture, presentation and PC hand-off.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valc_d   = valc_q;
        valp_d   = valp_q;
        icode_d  = icode_q;
        ifun_d   = ifun_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        idx_d    = idx_q;
        kidx_d   = kidx_q;
        err_d    = err_q;
        halted_d = halted_q;
        case (state_q)
            FETCH0: begin
                if (byte_vld) begin
                    icode_d = imem_rdata[7:4];
                    ifun_d  = imem_rdata[3:0];
                    err_d   = dec_illegal;
                    valp_d  = pc_q + {60'd0, len0};
                    idx_d   = idx_q + 4'd1;
                    if (dec_regids) begin
                        state_d = FETCHREG;
                    end else if (dec_valc) begin
                        state_d = FETCHC;
                    end else begin
                        state_d = PRESENT;
                    end
                end
            end
            FETCHREG: begin
                if (byte_vld) begin
                    ra_d    = imem_rdata[7:4];
                    rb_d    = imem_rdata[3:0];
                    idx_d   = idx_q + 4'd1;
                    state_d = dec_valc ? FETCHC : PRESENT;
                end
            end
            FETCHC: begin
                if (byte_vld) begin
                    valc_d[{kidx_q, 3'b000} +: 8] = imem_rdata;
                    idx_d  = idx_q + 4'd1;
                    kidx_d = kidx_q + 3'd1;
                    if (kidx_q == 3'd7) begin
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if ((icode_q == I_HALT) || err_q) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        state_d  = WAITPC;
                    end
                end
            end
            WAITPC: begin
                if (pc_load) begin
                    pc_d    = pc_in;
                    valc_d  = 64'd0;
                    ra_d    = RNONE;
                    rb_d    = RNONE;
                    idx_d   = 4'd0;
                    kidx_d  = 3'd0;
                    err_d   = 1'b0;
                    state_d = FETCH0;
                end
            end
            HALT: ;
            default: state_d = FETCH0;
        endcase
        // Request is registered from the next state so it is low out of reset and
        // rises the cycle after a PC load.
        req_d = (state_d == FETCH0) || (state_d == FETCHREG) || (state_d == FETCHC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH0;
            pc_q     <= RESET_PC;
            valc_q   <= 64'd0;
            valp_q   <= 64'd0;
            icode_q  <= 4'd0;
            ifun_q   <= 4'd0;
            ra_q     <= RNONE;
            rb_q     <= RNONE;
            idx_q    <= 4'd0;
            kidx_q   <= 3'd0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valc_q   <= valc_d;
            valp_q   <= valp_d;
            icode_q  <= icode_d;
            ifun_q   <= ifun_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            idx_q    <= idx_d;
            kidx_q   <= kidx_d;
            req_q    <= req_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = req_q ? (pc_q + {60'd0, idx_q}) : 64'd0;
    assign out_valid = (state_q == PRESENT);
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign pc        = pc_q;
    assign instr_err = err_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_seq_64.sv
// Bench for fetch_seq_64: byte memory with programmable ack delay, table vectors,
// hand-written corner sequences and random instructions against a length-table model.
// Ends with one summary line.
module tb_fetch_seq_64;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        err;
        int          len;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] b;
        int          dly;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_load = 1'b0;
    logic [63:0] pc_in = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_rdata = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc;
    logic        instr_err, halted;

    logic [7:0]  mem [logic [63:0]];
    logic [63:0] addr_log [$];
    int          req_cycles = 0;
    int          wcnt = 0;
    int          ack_delay = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    vec_t        tbl [$];

    fetch_seq_64 #(
        .RESET_PC  (64'h0),
        .MAX_ICODE (4'hB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .pc         (pc),
        .instr_err  (instr_err),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rdmem(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // Byte memory: answers a held request after ack_delay waiting cycles, logging each address served.
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end else begin
            req_cycles++;
            if (wcnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = rdmem(imem_addr);
                addr_log.push_back(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: decode purely from the instruction length table and the memory contents.
    function automatic exp_t model(input logic [63:0] p);
        exp_t       e;
        logic [7:0] b0, b1;
        int         off;
        b0      = rdmem(p);
        e.icode = b0[7:4];
        e.ifun  = b0[3:0];
        e.ra    = 4'hF;
        e.rb    = 4'hF;
        e.valc  = 64'd0;
        e.err   = (b0[7:4] > 4'hB);
        e.len   = e.err ? 1 : len_tab[b0[7:4]];
        off     = 1;
        if (e.len == 2 || e.len == 10) begin
            b1   = rdmem(p + 64'd1);
            e.ra = b1[7:4];
            e.rb = b1[3:0];
            off  = 2;
        end
        if (e.len >= 9) begin
            for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = rdmem(p + 64'(off + k));
        end
        e.valp = p + 64'(e.len);
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                                    input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                                    input logic er, input int ln);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.err = er; e.len = ln;
        return e;
    endfunction

    task automatic add_vec(input logic [63:0] p, input logic [79:0] b, input int dly, input exp_t e);
        vec_t v;
        v.pc = p; v.b = b; v.dly = dly; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic put_bytes(input logic [63:0] p, input logic [79:0] b, input int n);
        for (int i = 0; i < n; i++) mem[p + 64'(i)] = b[79 - 8*i -: 8];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".valid_in_time"}, 64'(out_valid), 64'd1);
    endtask

    task automatic check_instr(input string nm, input exp_t e, input logic [63:0] p);
        chk({nm, ".icode"}, 64'(icode), 64'(e.icode));
        chk({nm, ".ifun"},  64'(ifun),  64'(e.ifun));
        chk({nm, ".rA"},    64'(rA),    64'(e.ra));
        chk({nm, ".rB"},    64'(rB),    64'(e.rb));
        chk({nm, ".valC"},  valC,       e.valc);
        chk({nm, ".valP"},  valP,       e.valp);
        chk({nm, ".pc"},    pc,         p);
        chk({nm, ".err"},   64'(instr_err), 64'(e.err));
    endtask

    task automatic chk_log(input string nm, input int base, input logic [63:0] p, input int len);
        int ok = 1;
        chk({nm, ".nreq"}, 64'(addr_log.size() - base), 64'(len));
        for (int i = 0; i < len; i++) begin
            if (base + i >= addr_log.size()) ok = 0;
            else if (addr_log[base + i] !== p + 64'(i)) ok = 0;
        end
        chk({nm, ".addrs"}, 64'(ok), 64'd1);
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic load_pc(input logic [63:0] p);
        pc_load = 1'b1;
        pc_in   = p;
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic fetch_and_check(input string nm, input logic [63:0] p, input exp_t e, input int dly);
        int lb, rc;
        ack_delay = dly;
        lb = addr_log.size();
        rc = req_cycles;
        load_pc(p);
        wait_valid(nm, 300);
        check_instr(nm, e, p);
        chk_log(nm, lb, p, e.len);
        chk({nm, ".reqcyc"}, 64'(req_cycles - rc), 64'(e.len * (dly + 1)));
    endtask

    initial begin
        exp_t        irm, e;
        logic [79:0] b;
        logic [63:0] p;
        int          lb, rc, n;

        irm = mk_exp(4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 1'b0, 10);

        add_vec(64'h40, 80'h70_00_01_00_00_00_00_00_00_00, 3,
                mk_exp(4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h49, 1'b0, 9));
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 80'h10_00_00_00_00_00_00_00_00_00, 1,
                mk_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1));
        add_vec(64'h1000, 80'h21_12_00_00_00_00_00_00_00_00, 0,
                mk_exp(4'h2, 4'h1, 4'h1, 4'h2, 64'h0, 64'h1002, 1'b0, 2));
        add_vec(64'h2000, 80'h61_A3_00_00_00_00_00_00_00_00, 2,
                mk_exp(4'h6, 4'h1, 4'hA, 4'h3, 64'h0, 64'h2002, 1'b0, 2));
        add_vec(64'h3000, 80'h80_88_77_66_55_44_33_22_11_00, 0,
                mk_exp(4'h8, 4'h0, 4'hF, 4'hF, 64'h1122_3344_5566_7788, 64'h3009, 1'b0, 9));
        add_vec(64'h4000, 80'h90_00_00_00_00_00_00_00_00_00, 1,
                mk_exp(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4001, 1'b0, 1));
        add_vec(64'hFFFF_FFFF_FFFF_FFFC, 80'h50_15_08_00_00_00_00_00_00_00, 0,
                mk_exp(4'h5, 4'h0, 4'h1, 4'h5, 64'h8, 64'h6, 1'b0, 10));
        add_vec(64'h5000, 80'hA0_3F_00_00_00_00_00_00_00_00, 1,
                mk_exp(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h5002, 1'b0, 2));
        add_vec(64'h5002, 80'hB0_4F_00_00_00_00_00_00_00_00, 0,
                mk_exp(4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'h5004, 1'b0, 2));
        add_vec(64'h6000, 80'h40_63_F0_FF_FF_FF_FF_FF_FF_FF, 2,
                mk_exp(4'h4, 4'h0, 4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h600A, 1'b0, 10));

        // Reset values, then irmovq $10,%rbx fetched from RESET_PC.
        put_bytes(64'h0, 80'h30_F3_0A_00_00_00_00_00_00_00, 10);
        ack_delay = 0;
        repeat (2) @(negedge clk);
        chk("rst.req", 64'(imem_req), 64'd0);
        chk("rst.addr", imem_addr, 64'd0);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.halted", 64'(halted), 64'd0);
        check_instr("rst", mk_exp(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 0), 64'h0);
        lb = addr_log.size();
        rst_n = 1'b1;
        wait_valid("irmov", 300);
        check_instr("irmov", irm, 64'h0);
        chk_log("irmov", lb, 64'h0, 10);
        repeat (4) @(negedge clk);
        chk("irmov.hold_valid", 64'(out_valid), 64'd1);
        chk("irmov.hold_valC", valC, 64'd10);
        chk("irmov.hold_req", 64'(imem_req), 64'd0);
        accept();
        chk("irmov.dropped", 64'(out_valid), 64'd0);

        // Table vectors.
        foreach (tbl[i]) begin
            put_bytes(tbl[i].pc, tbl[i].b, tbl[i].e.len);
            fetch_and_check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].e, tbl[i].dly);
            accept();
        end

        // nop held under backpressure; pc_load during PRESENT is ignored.
        put_bytes(64'h7000, 80'h10_00_00_00_00_00_00_00_00_00, 1);
        fetch_and_check("nopstall", 64'h7000, mk_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h7001, 1'b0, 1), 0);
        rc = req_cycles;
        load_pc(64'h1234);
        repeat (4) @(negedge clk);
        chk("nopstall.valid", 64'(out_valid), 64'd1);
        chk("nopstall.pc", pc, 64'h7000);
        chk("nopstall.valP", valP, 64'h7001);
        chk("nopstall.icode", 64'(icode), 64'h1);
        chk("nopstall.noreq", 64'(req_cycles - rc), 64'd0);
        accept();
        mem[64'h80] = 8'h10;
        load_pc(64'h80);
        chk("load80.req", 64'(imem_req), 64'd1);
        chk("load80.addr", imem_addr, 64'h80);
        wait_valid("load80", 50);
        chk("load80.valP", valP, 64'h81);

        // pc_load coinciding with the PRESENT handshake is ignored.
        out_ready = 1'b1;
        pc_load   = 1'b1;
        pc_in     = 64'h5555;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        pc_load   = 1'b0;
        rc = req_cycles;
        repeat (3) @(negedge clk);
        chk("hs_load.valid", 64'(out_valid), 64'd0);
        chk("hs_load.pc", pc, 64'h80);
        chk("hs_load.noreq", 64'(req_cycles - rc), 64'd0);

        // Random legal non-halt instructions.
        for (int t = 0; t < 40; t++) begin
            p = {$urandom, $urandom};
            b = '0;
            b[79:72] = {4'($urandom_range(11, 1)), 4'($urandom_range(15, 0))};
            for (int i = 1; i < 10; i++) b[79 - 8*i -: 8] = 8'($urandom);
            put_bytes(p, b, 10);
            e = model(p);
            fetch_and_check($sformatf("rnd%0d", t), p, e, $urandom_range(2, 0));
            accept();
        end

        // Illegal icode: error flagged, halts after handshake, pc_load ignored.
        mem[64'h200] = 8'hC0;
        e = model(64'h200);
        fetch_and_check("illegal", 64'h200, e, 0);
        chk("illegal.valP", valP, 64'h201);
        accept();
        chk("illegal.halted", 64'(halted), 64'd1);
        chk("illegal.valid", 64'(out_valid), 64'd0);
        rc = req_cycles;
        load_pc(64'h10);
        repeat (8) @(negedge clk);
        chk("illegal.noreq", 64'(req_cycles - rc), 64'd0);
        chk("illegal.pc", pc, 64'h200);

        put_bytes(64'h0, 80'h30_F3_0A_00_00_00_00_00_00_00, 10);
        ack_delay = 3;
        #2 rst_n = 1'b0;
        #1;
        chk("rst2.halted", 64'(halted), 64'd0);
        chk("rst2.pc", pc, 64'h0);
        @(negedge clk);
        lb = addr_log.size();
        rst_n = 1'b1;

        // Reset while waiting for the 5th valC byte.
        n = 0;
        while (addr_log.size() - lb < 6 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.reached", 64'(addr_log.size() - lb), 64'd6);
        repeat (2) @(negedge clk);
        chk("midrst.pre_req", 64'(imem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.req", 64'(imem_req), 64'd0);
        chk("midrst.addr", imem_addr, 64'd0);
        chk("midrst.valC", valC, 64'd0);
        ack_delay = 0;
        @(negedge clk);
        lb = addr_log.size();
        rst_n = 1'b1;
        wait_valid("midrst", 300);
        check_instr("midrst", irm, 64'h0);
        chk_log("midrst", lb, 64'h0, 10);
        accept();

        // halt instruction: sticky halted, no requests, reset restarts at RESET_PC.
        mem[64'h300] = 8'h00;
        e = model(64'h300);
        fetch_and_check("halt", 64'h300, e, 1);
        accept();
        chk("halt.halted", 64'(halted), 64'd1);
        rc = req_cycles;
        load_pc(64'h0);
        repeat (8) @(negedge clk);
        chk("halt.noreq", 64'(req_cycles - rc), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst3.halted", 64'(halted), 64'd0);
        chk("rst3.pc", pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst3.req", 64'(imem_req), 64'd1);
        chk("rst3.addr", imem_addr, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
